// File: rtl/lpif_txrx_x4_f1_pkg.sv
// lpif_txrx_x4_f1_pkg: LPIF x4 full-rate 141-bit word layout, link states and pack/unpack helpers
package lpif_txrx_x4_f1_pkg;
    localparam int LINK_W     = 141;
    localparam int STATE_LSB  = 0;
    localparam int STATE_W    = 4;
    localparam int PROTID_LSB = 4;
    localparam int PROTID_W   = 2;
    localparam int DATA_LSB   = 6;
    localparam int DATA_W     = 128;
    localparam int DVALID_BIT = 134;
    localparam int CRC_LSB    = 135;
    localparam int CRC_W      = 4;
    localparam int CRCV_BIT   = 139;
    localparam int VALID_BIT  = 140;

    typedef enum logic [1:0] {
        OFFLINE = 2'd0,
        SYNC    = 2'd1,
        ONLINE  = 2'd2
    } link_state_e;

    // Field order MSB-first so the packed struct maps bit-for-bit onto the link word
    typedef struct packed {
        logic                valid;
        logic                crc_valid;
        logic [CRC_W-1:0]    crc;
        logic                dvalid;
        logic [DATA_W-1:0]   data;
        logic [PROTID_W-1:0] protid;
        logic [STATE_W-1:0]  state;
    } lpif_word_t;

    function automatic lpif_word_t unpack_word(input logic [LINK_W-1:0] w);
        return lpif_word_t'(w);
    endfunction

    function automatic logic [LINK_W-1:0] pack_word(input lpif_word_t f);
        return LINK_W'(f);
    endfunction
endpackage

// File: rtl/lpif_txrx_chk.sv
// lpif_txrx_chk: malformed-word detect on forwarded words plus saturating error counter with clear
module lpif_txrx_chk #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 lclk,
    input  logic                 rst,
    input  logic                 fwd,
    input  logic                 valid,
    input  logic                 dvalid,
    input  logic                 crc_valid,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic err;

    assign err = fwd & ((dvalid & ~valid) | (crc_valid & ~dvalid));

    always_ff @(posedge lclk or posedge rst)
        if (rst)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (err && err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;
endmodule

// File: rtl/lpif_txrx_x4_f1_slave_name_reg.sv
// lpif_txrx_x4_f1_slave_name_reg: slave-end LPIF x4 adapter, registered unpack/pack with link-state gating
module lpif_txrx_x4_f1_slave_name_reg
    import lpif_txrx_x4_f1_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 lclk,
    input  logic                 rst,
    input  logic                 rx_online,
    input  logic [LINK_W-1:0]    rxfifo_downstream_data,
    input  logic                 rxfifo_downstream_vld,
    output logic [3:0]           dstrm_state,
    output logic [1:0]           dstrm_protid,
    output logic [127:0]         dstrm_data,
    output logic                 dstrm_dvalid,
    output logic [3:0]           dstrm_crc,
    output logic                 dstrm_crc_valid,
    output logic                 dstrm_valid,
    input  logic [3:0]           ustrm_state,
    input  logic [1:0]           ustrm_protid,
    input  logic [127:0]         ustrm_data,
    input  logic                 ustrm_dvalid,
    input  logic [3:0]           ustrm_crc,
    input  logic                 ustrm_crc_valid,
    input  logic                 ustrm_valid,
    output logic [LINK_W-1:0]    txfifo_upstream_data,
    input  logic                 m_gen2_mode,
    output logic [1:0]           link_state,
    output logic                 state_chg,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    link_state_e state_q, state_d;
    lpif_word_t  rx_w, ds_q, us_w;
    logic        accept, fwd, online, unused_gen2;

    assign unused_gen2 = m_gen2_mode;
    assign rx_w        = unpack_word(rxfifo_downstream_data);
    assign online      = state_q == ONLINE;
    assign accept      = rxfifo_downstream_vld & rx_online & (state_q != OFFLINE);
    assign fwd         = accept & (online | rx_w.valid);

    // Loss of rx_online overrides every other transition
    always_comb
        state_d = !rx_online                      ? OFFLINE :
                  state_q == OFFLINE              ? SYNC    :
                  (state_q == SYNC && accept && rx_w.valid) ? ONLINE : state_q;

    always_ff @(posedge lclk or posedge rst)
        if (rst)
            state_q <= OFFLINE;
        else
            state_q <= state_d;

    always_ff @(posedge lclk or posedge rst)
        if (rst) begin
            ds_q      <= '0;
            state_chg <= 1'b0;
        end else if (fwd) begin
            ds_q      <= rx_w;
            state_chg <= rx_w.state != ds_q.state;
        end else begin
            ds_q.valid     <= 1'b0;
            ds_q.dvalid    <= 1'b0;
            ds_q.crc_valid <= 1'b0;
            state_chg      <= 1'b0;
        end

    always_comb
        us_w = '{valid:     ustrm_valid & online,
                 crc_valid: ustrm_crc_valid & online,
                 crc:       ustrm_crc,
                 dvalid:    ustrm_dvalid & online,
                 data:      ustrm_data,
                 protid:    ustrm_protid,
                 state:     ustrm_state};

    always_ff @(posedge lclk or posedge rst)
        if (rst)
            txfifo_upstream_data <= '0;
        else
            txfifo_upstream_data <= pack_word(us_w);

    assign dstrm_state     = ds_q.state;
    assign dstrm_protid    = ds_q.protid;
    assign dstrm_data      = ds_q.data;
    assign dstrm_dvalid    = ds_q.dvalid;
    assign dstrm_crc       = ds_q.crc;
    assign dstrm_crc_valid = ds_q.crc_valid;
    assign dstrm_valid     = ds_q.valid;
    assign link_state      = state_q;

    lpif_txrx_chk #(.ERR_CNT_W(ERR_CNT_W)) u_chk (
        .lclk      (lclk),
        .rst       (rst),
        .fwd       (fwd),
        .valid     (rx_w.valid),
        .dvalid    (rx_w.dvalid),
        .crc_valid (rx_w.crc_valid),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );
endmodule

// File: tb/tb_lpif_txrx_x4_f1_slave_name_reg.sv
// tb_lpif_txrx_x4_f1_slave_name_reg: behavioural-model bench with per-cycle compare and directed literal checks
module tb_lpif_txrx_x4_f1_slave_name_reg;
    localparam int EW = 2;

    logic         clk = 1'b0, rst;
    logic         rx_online, vld, err_clr, m_gen2_mode;
    logic [140:0] rxd;
    logic [3:0]   ustrm_state, ustrm_crc;
    logic [1:0]   ustrm_protid;
    logic [127:0] ustrm_data;
    logic         ustrm_dvalid, ustrm_crc_valid, ustrm_valid;
    logic [3:0]   dstrm_state, dstrm_crc;
    logic [1:0]   dstrm_protid, link_state;
    logic [127:0] dstrm_data;
    logic         dstrm_dvalid, dstrm_crc_valid, dstrm_valid, state_chg;
    logic [140:0] txfifo_upstream_data;
    logic [EW-1:0] err_cnt;

    int errs = 0, checks = 0;

    lpif_txrx_x4_f1_slave_name_reg #(.ERR_CNT_W(EW)) dut (
        .lclk(clk), .rst(rst), .rx_online(rx_online),
        .rxfifo_downstream_data(rxd), .rxfifo_downstream_vld(vld),
        .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
        .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
        .dstrm_valid(dstrm_valid), .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid),
        .ustrm_data(ustrm_data), .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc),
        .ustrm_crc_valid(ustrm_crc_valid), .ustrm_valid(ustrm_valid),
        .txfifo_upstream_data(txfifo_upstream_data), .m_gen2_mode(m_gen2_mode),
        .link_state(link_state), .state_chg(state_chg), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [140:0] a, input logic [140:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [140:0] mk(input bit v, input bit cv, input logic [3:0] crc, input bit dv,
                                        input logic [127:0] d, input logic [1:0] p, input logic [3:0] s);
        return {v, cv, crc, dv, d, p, s};
    endfunction

    // Reference model: link mode as an int, expected outputs as plain variables
    int           m_ls, e_err;
    logic [3:0]   e_state, e_crc;
    logic [1:0]   e_prot;
    logic [127:0] e_data;
    logic         e_dv, e_cv, e_v, e_chg;
    logic [140:0] e_tx;

    always @(posedge clk or posedge rst) begin : model
        bit acc, fw, bad;
        if (rst) begin
            m_ls <= 0; e_err <= 0; e_state <= 0; e_crc <= 0; e_prot <= 0; e_data <= 0;
            e_dv <= 0; e_cv <= 0; e_v <= 0; e_chg <= 0; e_tx <= 0;
        end else begin
            acc = vld && rx_online && m_ls != 0;
            fw  = acc && (m_ls == 2 || rxd[140]);
            bad = (!rxd[140] && (rxd[134] || rxd[139])) || (rxd[139] && !rxd[134]);
            if (fw) begin
                e_state <= rxd[3:0]; e_prot <= rxd[5:4]; e_data <= rxd[133:6]; e_dv <= rxd[134];
                e_crc <= rxd[138:135]; e_cv <= rxd[139]; e_v <= rxd[140]; e_chg <= rxd[3:0] != e_state;
            end else begin
                e_dv <= 0; e_cv <= 0; e_v <= 0; e_chg <= 0;
            end
            if (err_clr) e_err <= 0;
            else if (fw && bad && e_err < (1 << EW) - 1) e_err <= e_err + 1;
            e_tx <= {ustrm_valid && m_ls == 2, ustrm_crc_valid && m_ls == 2, ustrm_crc,
                     ustrm_dvalid && m_ls == 2, ustrm_data, ustrm_protid, ustrm_state};
            m_ls <= !rx_online ? 0 : m_ls == 0 ? 1 : (acc && rxd[140]) ? 2 : m_ls;
        end
    end

    always @(negedge clk) begin
        chk("m.link_state", 141'(link_state), 141'(m_ls));
        chk("m.dstrm_valid", 141'(dstrm_valid), 141'(e_v));
        chk("m.dstrm_dvalid", 141'(dstrm_dvalid), 141'(e_dv));
        chk("m.dstrm_crc_valid", 141'(dstrm_crc_valid), 141'(e_cv));
        chk("m.dstrm_fields", {dstrm_crc, dstrm_data, dstrm_protid, dstrm_state},
            {e_crc, e_data, e_prot, e_state});
        chk("m.state_chg", 141'(state_chg), 141'(e_chg));
        chk("m.err_cnt", 141'(err_cnt), 141'(e_err));
        chk("m.txfifo", txfifo_upstream_data, e_tx);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [140:0] tx;
    initial begin
        rst = 1; rx_online = 0; vld = 0; err_clr = 0; m_gen2_mode = 0; rxd = '0;
        ustrm_state = 0; ustrm_crc = 0; ustrm_protid = 0; ustrm_data = 0;
        ustrm_dvalid = 0; ustrm_crc_valid = 0; ustrm_valid = 0;
        repeat (2) step();
        chk("rst.link_state", 141'(link_state), 141'(0));
        chk("rst.dstrm_valid", 141'(dstrm_valid), 141'(0));
        rst = 0;
        step();
        rx_online = 1;
        step();
        chk("sync.link_state", 141'(link_state), 141'(1));
        vld = 1;
        for (int i = 0; i < 3; i++) begin
            rxd = mk(0, 0, 0, 0, 128'(i), 0, 4'h9);
            step();
            chk("sync.discard", 141'(dstrm_valid), 141'(0));
        end
        rxd = mk(1, 0, 0, 1, {16{8'hA5}}, 1, 4'h3);
        step();
        chk("sync.valid", 141'(dstrm_valid), 141'(1));
        chk("sync.state", 141'(dstrm_state), 141'(3));
        chk("sync.data", 141'(dstrm_data), 141'({16{8'hA5}}));
        chk("sync.link_state", 141'(link_state), 141'(2));
        chk("sync.state_chg", 141'(state_chg), 141'(1));
        for (int i = 0; i < 8; i++) begin
            rxd = mk(1, 1, 4'(i), 1, 128'(i + 100), 2, i == 5 ? 4'h7 : 4'h3);
            step();
            chk("b2b.data", 141'(dstrm_data), 141'(i + 100));
        end
        vld = 0;
        step();
        chk("gap.valid", 141'(dstrm_valid), 141'(0));
        chk("gap.data_held", 141'(dstrm_data), 141'(107));
        ustrm_state = 5; ustrm_protid = 2; ustrm_crc = 4'hC; ustrm_crc_valid = 1;
        ustrm_valid = 1; ustrm_dvalid = 1; ustrm_data = 128'h1234;
        step();
        tx = txfifo_upstream_data;
        chk("us.state", 141'(tx[3:0]), 141'(5));
        chk("us.protid", 141'(tx[5:4]), 141'(2));
        chk("us.crc", 141'(tx[138:135]), 141'(4'hC));
        chk("us.crc_valid", 141'(tx[139]), 141'(1));
        chk("us.valid", 141'(tx[140]), 141'(1));
        vld = 1;
        rxd = mk(0, 0, 0, 1, 128'hE, 0, 4'h3);
        for (int i = 0; i < 5; i++) step();
        chk("err.saturate", 141'(err_cnt), 141'(3));
        err_clr = 1;
        step();
        chk("err.clr", 141'(err_cnt), 141'(0));
        err_clr = 0;
        rxd = mk(1, 0, 0, 1, 128'hD0, 0, 4'h4);
        rx_online = 0;
        step();
        chk("drop.valid", 141'(dstrm_valid), 141'(0));
        chk("drop.link_state", 141'(link_state), 141'(0));
        step();
        tx = txfifo_upstream_data;
        chk("drop.tx_valids", 141'({tx[140], tx[139], tx[134]}), 141'(0));
        chk("drop.tx_state", 141'(tx[3:0]), 141'(5));
        vld = 0;
        rx_online = 1;
        step();
        vld = 1;
        rxd = mk(1, 0, 0, 0, 128'h55, 0, 4'h1);
        step();
        rxd = mk(1, 1, 4'h2, 0, 128'h66, 0, 4'h1);
        step();
        chk("pre_rst.err_cnt", 141'(err_cnt), 141'(1));
        chk("pre_rst.valid", 141'(dstrm_valid), 141'(1));
        rst = 1;
        #1;
        chk("arst.valid", 141'(dstrm_valid), 141'(0));
        chk("arst.link_state", 141'(link_state), 141'(0));
        chk("arst.err_cnt", 141'(err_cnt), 141'(0));
        chk("arst.tx", txfifo_upstream_data, 141'(0));
        chk("arst.data", 141'(dstrm_data), 141'(0));
        step();
        rst = 0;
        vld = 0;
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
